// File: rtl/casr_word_packer_if.sv
// casr_word_packer_if: valid/ready word output bus of the CASR word packer
//   o_word        packed output word
//   o_word_valid  o_word holds an untaken word
//   i_word_ready  consumer accepts o_word when valid&ready
interface casr_word_packer_if #(
    parameter int WORD_W = 16
);
    logic [WORD_W-1:0] o_word;
    logic              o_word_valid;
    logic              i_word_ready;
    modport master (output o_word, o_word_valid, input i_word_ready);
    modport slave  (input o_word, o_word_valid, output i_word_ready);
endinterface

// File: rtl/casr_word_packer.sv
// casr_word_packer: gates CASR advance, warms up, decimates one state bit per DECIM steps into WORD_W-bit words
//   clk, rst      clock, synchronous active-high reset
//   i_start       pulse: leave IDLE and begin warm-up
//   i_stop        pulse: return to IDLE, discarding the partial word
//   i_casr_state  current CASR state
//   o_casr_en     CASR advance enable
//   o_busy        not IDLE
//   o_warm        in warm-up
//   o_wp          word output handshake (master side)
module casr_word_packer #(
    parameter int STATE_W = 37,
    parameter int WORD_W  = 16,
    parameter int TAP     = 18,
    parameter int WARMUP  = 64,
    parameter int DECIM   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic [STATE_W-1:0]    i_casr_state,
    output logic                  o_casr_en,
    output logic                  o_busy,
    output logic                  o_warm,
    casr_word_packer_if.master    o_wp
);
    localparam int WW = $clog2(WARMUP + 1);
    localparam int SW = DECIM > 1 ? $clog2(DECIM) : 1;
    localparam int BW = $clog2(WORD_W);

    typedef enum logic [1:0] {S_IDLE, S_WARM, S_RUN} state_t;

    state_t            r_state;
    logic [WW-1:0]     r_warm;
    logic [SW-1:0]     r_step;
    logic [BW-1:0]     r_bit;
    logic [WORD_W-1:0] r_acc;
    logic              r_acc_full;

    logic              w_take;
    logic              w_step_wrap;
    logic              w_cap;
    logic              w_done;
    logic [WORD_W-1:0] w_acc;
    logic              w_unused;

    always_comb begin
        o_casr_en   = (r_state == S_WARM) | ((r_state == S_RUN) & !r_acc_full);
        o_busy      = r_state != S_IDLE;
        o_warm      = r_state == S_WARM;
        w_take      = o_wp.o_word_valid & o_wp.i_word_ready;
        w_step_wrap = r_step == SW'(DECIM - 1);
        // The step counter runs through warm-up too, so decimation phase follows total CASR steps.
        w_cap       = o_casr_en & (r_state == S_RUN) & w_step_wrap;
        w_done      = w_cap & (r_bit == BW'(WORD_W - 1));
        w_acc       = {r_acc[WORD_W-2:0], i_casr_state[TAP]};
        w_unused    = ^i_casr_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= S_IDLE;
            r_warm            <= '0;
            r_step            <= '0;
            r_bit             <= '0;
            r_acc             <= '0;
            r_acc_full        <= 1'b0;
            o_wp.o_word       <= '0;
            o_wp.o_word_valid <= 1'b0;
        end else begin
            if (w_take)
                o_wp.o_word_valid <= 1'b0;
            if (i_stop && r_state != S_IDLE) begin
                r_state    <= S_IDLE;
                r_warm     <= '0;
                r_step     <= '0;
                r_bit      <= '0;
                r_acc      <= '0;
                r_acc_full <= 1'b0;
            end else begin
                // A parked word replaces the one being taken, keeping valid high with no bubble.
                if (r_acc_full && w_take) begin
                    o_wp.o_word       <= r_acc;
                    o_wp.o_word_valid <= 1'b1;
                    r_acc_full        <= 1'b0;
                end
                case (r_state)
                    S_IDLE: if (i_start && !i_stop) r_state <= S_WARM;
                    S_WARM: begin
                        r_step  <= w_step_wrap ? '0 : r_step + 1'b1;
                        r_warm  <= r_warm == WW'(WARMUP - 1) ? '0 : r_warm + 1'b1;
                        r_state <= r_warm == WW'(WARMUP - 1) ? S_RUN : S_WARM;
                    end
                    S_RUN: begin
                        if (o_casr_en)
                            r_step <= w_step_wrap ? '0 : r_step + 1'b1;
                        if (w_cap) begin
                            r_acc <= w_acc;
                            r_bit <= w_done ? '0 : r_bit + 1'b1;
                        end
                        if (w_done && (!o_wp.o_word_valid || w_take)) begin
                            o_wp.o_word       <= w_acc;
                            o_wp.o_word_valid <= 1'b1;
                        end else if (w_done) begin
                            r_acc_full <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_casr_word_packer.sv
// tb_casr_word_packer: scoreboard bench for casr_word_packer with counter-based CASR models
module tb_casr_word_packer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start1 = 1'b0, stop1 = 1'b0, start2 = 1'b0, stop2 = 1'b0;
    logic        en1, en2, busy1, busy2, warm1, warm2;
    logic [36:0] cnt1 = '0, cnt2 = '0;
    logic [3:0]  q1[$], q2[$];
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    casr_word_packer_if #(.WORD_W(4)) wp1 ();
    casr_word_packer_if #(.WORD_W(4)) wp2 ();

    casr_word_packer #(.STATE_W(37), .WORD_W(4), .TAP(0), .WARMUP(3), .DECIM(1)) dut1 (
        .clk(clk), .rst(rst), .i_start(start1), .i_stop(stop1), .i_casr_state(cnt1),
        .o_casr_en(en1), .o_busy(busy1), .o_warm(warm1), .o_wp(wp1.master)
    );

    casr_word_packer #(.STATE_W(37), .WORD_W(4), .TAP(0), .WARMUP(3), .DECIM(2)) dut2 (
        .clk(clk), .rst(rst), .i_start(start2), .i_stop(stop2), .i_casr_state(cnt2),
        .o_casr_en(en2), .o_busy(busy2), .o_warm(warm2), .o_wp(wp2.master)
    );

    always @(posedge clk) begin
        cnt1 <= rst ? '0 : cnt1 + 37'(en1);
        cnt2 <= rst ? '0 : cnt2 + 37'(en2);
    end

    always @(negedge clk) begin
        logic [3:0] e;
        if (!rst && wp1.o_word_valid && wp1.i_word_ready) begin
            n_chk++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL word1_unexpected: got %h with no word expected", wp1.o_word);
            end else begin
                e = q1.pop_front();
                if (wp1.o_word !== e) begin
                    n_fail++;
                    $display("FAIL word1: got %h expected %h", wp1.o_word, e);
                end
            end
        end
        if (!rst && wp2.o_word_valid && wp2.i_word_ready) begin
            n_chk++;
            if (q2.size() == 0) begin
                n_fail++;
                $display("FAIL word2_unexpected: got %h with no word expected", wp2.o_word);
            end else begin
                e = q2.pop_front();
                if (wp2.o_word !== e) begin
                    n_fail++;
                    $display("FAIL word2: got %h expected %h", wp2.o_word, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        q1.delete();
        q2.delete();
    endtask

    task automatic pulse_start1();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lows;
        int w;
        wp1.i_word_ready = 1'b1;
        wp2.i_word_ready = 1'b1;
        do_reset();
        ticks(10);
        chk("idle_en", en1, 0);
        chk("idle_valid", wp1.o_word_valid, 0);
        chk("idle_word", wp1.o_word, 0);
        chk("idle_busy", busy1, 0);
        chk("idle_warm", warm1, 0);

        for (int i = 0; i < 4; i++) q1.push_back(4'hA);
        pulse_start1();
        chk("c1_warm", warm1, 1);
        chk("c1_busy", busy1, 1);
        ticks(2);
        chk("c3_warm", warm1, 1);
        tick();
        chk("c4_warm", warm1, 0);
        chk("c4_cnt", cnt1, 3);
        ticks(4);
        chk("c8_valid", wp1.o_word_valid, 1);
        chk("c8_word", wp1.o_word, 4'hA);
        lows = 0;
        for (int i = 0; i < 12; i++) begin
            if (!en1) lows++;
            tick();
        end
        chk("b2b_en_low_cycles", lows, 0);
        tick();
        chk("b2b_q_empty", q1.size(), 0);

        do_reset();
        wp1.i_word_ready = 1'b0;
        q1.push_back(4'hA);
        q1.push_back(4'hA);
        pulse_start1();
        ticks(11);
        chk("bp_c12_en", en1, 0);
        chk("bp_c12_cnt", cnt1, 11);
        chk("bp_c12_valid", wp1.o_word_valid, 1);
        chk("bp_c12_word", wp1.o_word, 4'hA);
        tick();
        chk("bp_c13_cnt", cnt1, 11);
        tick();
        wp1.i_word_ready = 1'b1;
        tick();
        wp1.i_word_ready = 1'b0;
        chk("bp_c15_valid", wp1.o_word_valid, 1);
        chk("bp_c15_word", wp1.o_word, 4'hA);
        chk("bp_c15_en", en1, 1);
        chk("bp_c15_cnt", cnt1, 11);
        tick();
        chk("bp_c16_cnt", cnt1, 12);
        ticks(3);
        chk("bp_c19_en_full", en1, 0);
        chk("bp_c19_valid", wp1.o_word_valid, 1);

        rst = 1'b1;
        q1.delete();
        tick();
        chk("rst_en", en1, 0);
        chk("rst_valid", wp1.o_word_valid, 0);
        chk("rst_word", wp1.o_word, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_warm", warm1, 0);
        rst = 1'b0;
        wp1.i_word_ready = 1'b1;
        q1.push_back(4'hA);
        pulse_start1();
        tick();
        pulse_start1();
        chk("restart_c3_warm", warm1, 1);
        tick();
        chk("restart_c4_warm", warm1, 0);
        chk("restart_c4_cnt", cnt1, 3);
        ticks(4);
        chk("restart_c8_valid", wp1.o_word_valid, 1);
        stop1 = 1'b1;
        tick();
        stop1 = 1'b0;
        chk("restart_stop_busy", busy1, 0);

        do_reset();
        wp1.i_word_ready = 1'b0;
        q1.push_back(4'hA);
        pulse_start1();
        ticks(8);
        stop1 = 1'b1;
        tick();
        stop1 = 1'b0;
        chk("stop_busy", busy1, 0);
        chk("stop_en", en1, 0);
        chk("stop_valid_kept", wp1.o_word_valid, 1);
        chk("stop_word_kept", wp1.o_word, 4'hA);
        chk("stop_cnt", cnt1, 9);
        ticks(3);
        chk("stop_cnt_frozen", cnt1, 9);
        wp1.i_word_ready = 1'b1;
        tick();
        wp1.i_word_ready = 1'b0;
        chk("stop_valid_drained", wp1.o_word_valid, 0);
        q1.push_back(4'h5);
        pulse_start1();
        ticks(3);
        chk("stop_rewarm_cnt", cnt1, 12);
        ticks(4);
        chk("stop_fresh_valid", wp1.o_word_valid, 1);
        chk("stop_fresh_word", wp1.o_word, 4'h5);
        wp1.i_word_ready = 1'b1;
        tick();
        wp1.i_word_ready = 1'b0;
        stop1 = 1'b1;
        tick();
        stop1 = 1'b0;

        q2.push_back(4'hF);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        lows = 0;
        for (int i = 0; i < 10; i++) begin
            if (!en2) lows++;
            tick();
        end
        chk("decim2_en_low_cycles", lows, 0);
        w = 0;
        while (!wp2.o_word_valid && w < 20) begin
            tick();
            w++;
        end
        chk("decim2_valid_seen", wp2.o_word_valid, 1);
        chk("decim2_word", wp2.o_word, 4'hF);
        stop2 = 1'b1;
        tick();
        stop2 = 1'b0;
        ticks(2);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
